// File: rtl/rnd_range_sampler.sv
// Reduces raw LFSR words modulo a caller range with a bit-serial restoring remainder.
// Optional feature macro: RND_DEDUP_EN suppresses a result equal to the last transferred one.
module rnd_range_sampler #(
    parameter int RAW_W   = 13,
    parameter int RANGE_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               raw_valid,
    output logic               raw_ready,
    input  logic [RAW_W-1:0]   raw_data,
    input  logic [RANGE_W-1:0] range,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RANGE_W-1:0] out_data,
    output logic               busy
);

    // Handshakes: a word moves on a rising edge where valid && ready are both high;
    // valid never drops without a transfer, and ready does not depend on valid.

    localparam int CNT_W = $clog2(RAW_W);
    localparam int REM_W = RANGE_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RAW_W-1:0]   raw_q, raw_d;
    logic [RANGE_W-1:0] range_q, range_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RANGE_W-1:0] out_q, out_d;

    logic [REM_W-1:0]   rem_shift;
    logic [REM_W-1:0]   rem_next;
    logic               drop;

`ifdef RND_DEDUP_EN
    logic [RANGE_W-1:0] hist_q, hist_d;
    logic               hist_vld_q, hist_vld_d;
`endif

    // Remainder stays below range, so its low RANGE_W bits hold it losslessly before the shift.
    always_comb begin
        rem_shift = {rem_q[RANGE_W-1:0], raw_q[cnt_q]};
        if (rem_shift >= {1'b0, range_q}) begin
            rem_next = rem_shift - {1'b0, range_q};
        end else begin
            rem_next = rem_shift;
        end
    end

`ifdef RND_DEDUP_EN
    // Ranges 0 and 1 only ever yield 0, so they must not be filtered or they would stall.
    always_comb begin
        drop = hist_vld_q && (range_q > RANGE_W'(1)) && (rem_next[RANGE_W-1:0] == hist_q);
    end
`else
    always_comb begin
        drop = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        raw_d   = raw_q;
        range_d = range_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
`ifdef RND_DEDUP_EN
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (raw_valid) begin
                    raw_d   = raw_data;
                    range_d = range;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(RAW_W - 1);
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (range_q == '0) begin
                    out_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    rem_d = rem_next;
                    if (cnt_q == '0) begin
                        if (drop) begin
                            state_d = S_IDLE;
                        end else begin
                            out_d   = rem_next[RANGE_W-1:0];
                            state_d = S_HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef RND_DEDUP_EN
                    hist_d     = out_q;
                    hist_vld_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            raw_q   <= '0;
            range_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
            range_q <= range_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

`ifdef RND_DEDUP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
        end
    end
`endif

    assign raw_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_rnd_range_sampler.sv
// Directed bench for rnd_range_sampler: expected results queued at issue, checked by a monitor.
module tb_rnd_range_sampler;

    localparam int RAW_W   = 13;
    localparam int RANGE_W = 11;

    logic               clk;
    logic               rst_n;
    logic               raw_valid;
    logic               raw_ready;
    logic [RAW_W-1:0]   raw_data;
    logic [RANGE_W-1:0] range;
    logic               out_valid;
    logic               out_ready;
    logic [RANGE_W-1:0] out_data;
    logic               busy;

    logic [RANGE_W-1:0] exp_q[$];
    int n_vec;
    int n_err;

    rnd_range_sampler #(.RAW_W(RAW_W), .RANGE_W(RANGE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_valid (raw_valid),
        .raw_ready (raw_ready),
        .raw_data  (raw_data),
        .range     (range),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard monitor: a transfer happens on the posedge following a negedge with valid && ready
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %0d, required no output", out_data);
            end else begin
                logic [RANGE_W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL out_data: got %0d, required %0d", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // drive a raw word; returns just after the accepting edge
    task automatic send(input logic [RAW_W-1:0] r, input logic [RANGE_W-1:0] m,
                        input logic [RANGE_W-1:0] e, input bit push);
        int guard;
        @(negedge clk);
        raw_valid = 1'b1;
        raw_data  = r;
        range     = m;
        guard = 0;
        while (!raw_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!raw_ready) begin
            chk("accept_timeout", 32'(raw_ready), 32'd1);
        end
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
        raw_data  = '0;
        range     = '0;
    endtask

    // count edges from the accept edge until out_valid is seen
    task automatic measure_lat(output int k);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2;
        out_ready = v;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        raw_valid = 1'b0;
        raw_data  = '0;
        range     = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_raw_ready", 32'(raw_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  32'(out_data),  32'd0);
        chk("reset_busy",      32'(busy),      32'd0);

        // 100 mod 7 with latency check
        send(13'd100, 11'd7, 11'd2, 1'b1);
        @(negedge clk);
        chk("busy_in_reduce", 32'(busy), 32'd1);
        measure_lat(lat);
        chk("latency_range7", 32'(lat + 1), 32'd13);
        set_ready(1'b1);
        drain();

        send(13'd8191, 11'd2047, 11'd3, 1'b1);
        send(13'd5, 11'd2000, 11'd5, 1'b1);
        drain();

        // range 0: result 0 one edge after accept
        out_ready = 1'b0;
        send(13'd1234, 11'd0, 11'd0, 1'b1);
        measure_lat(lat);
        chk("latency_range0", 32'(lat), 32'd1);
        set_ready(1'b1);
        drain();

        // range 1: result 0 after full reduction
        out_ready = 1'b0;
        send(13'd8191, 11'd1, 11'd0, 1'b1);
        measure_lat(lat);
        chk("latency_range1", 32'(lat), 32'd13);
        set_ready(1'b1);
        drain();

        // backpressure: 1000 mod 37 = 1 held for 20 cycles, stray raw pulse ignored
        out_ready = 1'b0;
        send(13'd1000, 11'd37, 11'd1, 1'b1);
        measure_lat(lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                raw_valid = 1'b1;
                raw_data  = 13'd55;
                range     = 11'd9;
            end else begin
                raw_valid = 1'b0;
            end
            chk("hold_out_data",  32'(out_data),  32'd1);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_raw_ready", 32'(raw_ready), 32'd0);
        end
        raw_valid = 1'b0;
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("post_xfer_raw_ready", 32'(raw_ready), 32'd1);
        chk("post_xfer_out_valid", 32'(out_valid), 32'd0);
        drain();

        // reset during REDUCE cycle 6
        send(13'd4000, 11'd100, 11'd0, 1'b0);
        repeat (6) @(negedge clk);
        chk("mid_reduce_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_raw_ready", 32'(raw_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(13'd20, 11'd6, 11'd2, 1'b1);
        drain();

        // repeated result: suppressed only when the dedup feature is built
        send(13'd9, 11'd4, 11'd1, 1'b1);
        drain();
`ifdef RND_DEDUP_EN
        send(13'd9, 11'd4, 11'd1, 1'b0);
`else
        send(13'd9, 11'd4, 11'd1, 1'b1);
`endif
        send(13'd10, 11'd4, 11'd2, 1'b1);
        drain();
        repeat (20) @(negedge clk);
        chk("no_trailing_output", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
